// File: rtl/module_key_capture.sv
// Key capture: priority-encodes debounced key pulses into a small FWFT FIFO with sticky drop flags.
// Optional repeat filter enabled by defining KEYCAP_REPEAT_FILTER_EN.
module module_key_capture #(
  parameter int N_KEYS      = 16,
  parameter int CODE_W      = 4,
  parameter int DEPTH       = 4,
  parameter int REPEAT_HOLD = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_KEYS-1:0]          key_pulse,
  output logic                       key_valid,
  output logic [CODE_W-1:0]          key_code,
  input  logic                       key_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       collision,
  input  logic                       clear_flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((N_KEYS < 2) || (N_KEYS > 16) || ((1 << CODE_W) < N_KEYS) ||
      (DEPTH < 2) || ((1 << PTR_W) != DEPTH) || (REPEAT_HOLD < 0)) begin : g_param_check
    $error("module_key_capture: illegal parameter combination");
  end

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              collision_q, collision_d;

  logic              push_req;
  logic [CODE_W-1:0] push_code;
  logic              multi_hit;
  logic              filt_hit;
  logic              push_acc;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic              ovf_set;

  // Encode: lowest set bit wins, so scan from the top down.
  always_comb begin
    push_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i]) push_code = CODE_W'(i);
    end
  end

  assign push_req  = |key_pulse;
  assign multi_hit = |(key_pulse & (key_pulse - N_KEYS'(1)));

`ifdef KEYCAP_REPEAT_FILTER_EN
  localparam int HOLD_W = $clog2(REPEAT_HOLD + 1);

  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign filt_hit = (hold_cnt_q != '0) && (push_code == last_code_q);

  // A repeat within the hold window neither reloads nor stops the countdown.
  always_comb begin
    last_code_d = last_code_q;
    hold_cnt_d  = hold_cnt_q;
    if (do_push) begin
      last_code_d = push_code;
      hold_cnt_d  = HOLD_W'(REPEAT_HOLD);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_code_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      last_code_q <= last_code_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end
`else
  assign filt_hit = 1'b0;
`endif

  // Push/pop decisions; a full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc = push_req && !filt_hit;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = key_valid && key_ready;
  assign do_push  = push_acc && (!full || do_pop);
  assign ovf_set  = push_acc && full && !do_pop;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d  = overflow_q;
    collision_d = collision_q;
    if (clear_flags) begin
      overflow_d  = 1'b0;
      collision_d = 1'b0;
    end
    if (ovf_set)   overflow_d  = 1'b1;
    if (multi_hit) collision_d = 1'b1;
  end

  // Storage holds data only; it is never reset, the pointers make stale words invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      collision_q <= collision_d;
    end
  end

  // Output stage: head word is masked to zero while empty.
  assign key_valid  = (count_q != '0);
  assign key_code   = key_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign collision  = collision_q;

endmodule

// File: tb/tb_module_key_capture.sv
// Directed bench for module_key_capture; filter scenarios run when KEYCAP_REPEAT_FILTER_EN is defined.
module tb_module_key_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key_pulse;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        collision;
  logic        clear_flags;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  module_key_capture #(
    .N_KEYS(16), .CODE_W(4), .DEPTH(4), .REPEAT_HOLD(10)
  ) dut (
    .clk(clk), .reset(reset), .key_pulse(key_pulse), .key_valid(key_valid),
    .key_code(key_code), .key_ready(key_ready), .fifo_count(fifo_count),
    .overflow(overflow), .collision(collision), .clear_flags(clear_flags)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_pulse = 16'h0001 << k;
    step();
    key_pulse = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pop_expect(input string tag, input int code);
    chk({tag, "_valid"}, int'(key_valid), 1);
    chk({tag, "_code"}, int'(key_code), code);
    key_ready = 1'b1;
    step();
    key_ready = 1'b0;
  endtask

  int exp_q [4] = '{3, 7, 9, 12};

  initial begin
    reset = 1'b1; key_pulse = '0; key_ready = 1'b0; clear_flags = 1'b0;
    #2;
    step();
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_coll", int'(collision), 0);
    reset = 1'b0;
    step();

    // Single key, one-cycle latency, then pop
    press(5);
    chk("k5_valid", int'(key_valid), 1);
    chk("k5_code", int'(key_code), 5);
    chk("k5_count", int'(fifo_count), 1);
    key_ready = 1'b1; step(); key_ready = 1'b0;
    chk("k5_pop_valid", int'(key_valid), 0);
    chk("k5_pop_count", int'(fifo_count), 0);

    // Ready while empty is ignored
    key_ready = 1'b1; step(); key_ready = 1'b0;
    chk("empty_rdy_count", int'(fifo_count), 0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 4; i++) press(exp_q[i]);
    chk("fill_count", int'(fifo_count), 4);
    chk("fill_ovf", int'(overflow), 0);
    press(1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(fifo_count), 4);
    chk("ovf_head", int'(key_code), 3);
    for (int i = 0; i < 4; i++) pop_expect("drain", exp_q[i]);
    chk("drain_count", int'(fifo_count), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    // Full with simultaneous push and pop: no overflow, new code at tail
    for (int i = 0; i < 4; i++) press(exp_q[i]);
    key_pulse = 16'h0004; key_ready = 1'b1;
    step();
    key_pulse = '0; key_ready = 1'b0;
    chk("fullpp_count", int'(fifo_count), 4);
    chk("fullpp_ovf", int'(overflow), 0);
    pop_expect("wrap0", 7);
    pop_expect("wrap1", 9);
    pop_expect("wrap2", 12);
    pop_expect("wrap3", 2);
    chk("wrap_empty", int'(key_valid), 0);
    idle(12);

    // Collision: lowest index wins, sticky, set beats clear
    key_pulse = 16'h0024; step(); key_pulse = '0;
    chk("coll_flag", int'(collision), 1);
    chk("coll_code", int'(key_code), 2);
    chk("coll_count", int'(fifo_count), 1);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    chk("coll_clear", int'(collision), 0);
    key_pulse = 16'h0003; clear_flags = 1'b1; step();
    key_pulse = '0; clear_flags = 1'b0;
    chk("coll_set_wins", int'(collision), 1);
    chk("coll_count2", int'(fifo_count), 2);
    pop_expect("coll_q0", 2);
    pop_expect("coll_q1", 0);
    clear_flags = 1'b1; step(); clear_flags = 1'b0;

`ifdef KEYCAP_REPEAT_FILTER_EN
    // Repeat filter with a 10-cycle hold window
    press(4);
    idle(4);
    press(4);
    chk("filt_same_count", int'(fifo_count), 1);
    chk("filt_no_ovf", int'(overflow), 0);
    idle(14);
    press(4);
    chk("filt_expired_count", int'(fifo_count), 2);
    pop_expect("filt_q0", 4);
    pop_expect("filt_q1", 4);
    idle(12);
    press(4);
    press(6);
    chk("filt_diff_count", int'(fifo_count), 2);
    pop_expect("filt_d0", 4);
    pop_expect("filt_d1", 6);
`else
    // Without the filter, back-to-back repeats are both queued
    press(4);
    press(4);
    chk("nofilt_count", int'(fifo_count), 2);
    pop_expect("nofilt_q0", 4);
    pop_expect("nofilt_q1", 4);
`endif
    idle(12);

    // Reset mid-operation with flags set and a push in flight
    press(1); press(2); press(3); press(4);
    press(5);
    key_ready = 1'b1; step(); key_ready = 1'b0;
    key_pulse = 16'h0006; key_ready = 1'b1; step();
    key_pulse = '0; key_ready = 1'b0;
    chk("pre_rst_count", int'(fifo_count), 3);
    chk("pre_rst_ovf", int'(overflow), 1);
    chk("pre_rst_coll", int'(collision), 1);
    key_pulse = 16'h0100; key_ready = 1'b1; reset = 1'b1;
    step();
    key_pulse = '0; key_ready = 1'b0; reset = 1'b0;
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_ovf", int'(overflow), 0);
    chk("mid_rst_coll", int'(collision), 0);
    chk("mid_rst_code", int'(key_code), 0);
    step();
    chk("post_rst_count", int'(fifo_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/module_key_capture.md
Name: module_key_capture

Overview:
- Downstream consumer of the debouncer bank. Takes one single-cycle debounced pulse per key and priority-encodes it to a key code.
- Queues codes in a small first-word-fall-through (FWFT) FIFO and presents them to the application logic (calculator/FSM) over a valid/ready handshake.
- Ensures no key event is lost while the consumer is busy, and reports drops via sticky flags.

Parameters:
- N_KEYS, 16, number of key pulse inputs (one debouncer each); 2..16.
- CODE_W, 4, key code width; must satisfy 2^CODE_W >= N_KEYS.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- REPEAT_HOLD, 1000, clock cycles of the repeat-filter window (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_pulse  in  N_KEYS  one-cycle pulses from the debouncers; bit i = key i.
- key_valid  out  1  FIFO non-empty; key_code is valid.
- key_code  out  CODE_W  code at the FIFO head (index of the key).
- key_ready  in  1  consumer accepts the head when key_valid && key_ready.
- fifo_count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.
- collision  out  1  sticky: more than one key_pulse bit was set in one cycle.
- clear_flags  in  1  one-cycle pulse; clears overflow and collision.

Behaviour:
- Reset, sampled at a clock edge with reset=1:
  - wr_ptr, rd_ptr and count go to 0.
  - key_valid=0, key_code=0, fifo_count=0, overflow=0, collision=0.
  - The repeat-filter state is cleared.
  - Reset overrides every other input in that cycle, including any in-flight push or pop; FIFO contents are discarded.
- Encode:
  - push_req = |key_pulse.
  - push_code = index of the lowest set bit (key 0 has the highest priority).
  - Purely combinational; sampled at the clock edge.
- Collision:
  - If popcount(key_pulse) >= 2, collision <= 1 in that edge.
  - Only the lowest-index code is pushed; the other keys are discarded.
- Push: when push_req and space is available, mem[wr_ptr] <= push_code and wr_ptr increments, wrapping modulo DEPTH.
- Pop: when key_valid && key_ready, rd_ptr increments, wrapping modulo DEPTH.
- FWFT output:
  - key_valid = (count != 0).
  - key_code = mem[rd_ptr], driven from registers; no extra cycle on pop.
- Latency:
  - A pulse at edge k gives key_valid=1 and key_code at the output after edge k, i.e. in cycle k+1.
  - No combinational path from key_pulse to key_valid/key_code.
- Full (count==DEPTH):
  - With a push and no pop: drop the push, overflow <= 1, contents unchanged.
  - With a push and a pop in the same cycle: both happen and count stays DEPTH; no overflow.
- Empty (count==0):
  - key_ready is ignored, with no underflow.
  - A push while empty makes key_valid=1 on the next cycle. No bypass in the same cycle.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- fifo_count equals count, registered.
- Sticky flags:
  - Setting wins over clear_flags in the same cycle (set has priority).
  - Otherwise clear_flags=1 forces the flags to 0.
- Handshake rule: key_code is stable while key_valid=1 && key_ready=0.
- No internal state machine beyond the FIFO pointers; the counter widths are as listed in Ports.

Optional Feature:
- Macro: KEYCAP_REPEAT_FILTER_EN.
- Defined:
  - A filter stage between encode and push holds last_code and a hold counter of width $clog2(REPEAT_HOLD+1).
  - Each accepted push loads last_code=push_code and sets the counter to REPEAT_HOLD; the counter decrements to 0 and saturates there.
  - A push_req with push_code==last_code while counter!=0 is discarded: no push and no overflow. The counter is not reloaded.
  - A different code is pushed normally and reloads the filter.
  - A filtered push does not set overflow.
  - reset clears last_code and the counter, so the first press is always accepted.
- Undefined:
  - Every push_req goes straight to the FIFO.
  - No filter registers are synthesized; REPEAT_HOLD is ignored.

Test Plan:
- Reset, then a single pulse on key_pulse[5] with key_ready=0 -> next cycle key_valid=1, key_code=5, fifo_count=1. Then assert key_ready for 1 cycle -> key_valid=0, fifo_count=0.
- Pulses on keys 3, 7, 9, 12 on separate cycles with key_ready=0 -> fifo_count=4. Then a pulse on key 1 -> overflow=1 and fifo_count stays 4. Drain -> codes 3, 7, 9, 12 in order.
- FIFO full (DEPTH=4); in one cycle pulse key 2 with key_ready=1 -> fifo_count stays 4, overflow=0, and key 2 ends up at the tail after the wrap.
- key_pulse=16'h0024 in one cycle -> code 2 queued, collision=1. clear_flags pulse -> collision=0. Set and clear in the same cycle -> collision stays 1.
- With KEYCAP_REPEAT_FILTER_EN and REPEAT_HOLD=10:
  - Key 4 at t=0 and t=5 -> only one entry queued.
  - Key 4 at t=20 -> second entry queued.
  - Key 4 then key 6 one cycle apart -> both queued.
- Assert reset while fifo_count=3 and a push is occurring -> next cycle fifo_count=0, key_valid=0, overflow=0, collision=0.
